fetch_branch_sequencer: RTL and testbench
=========================================

// Module: fetch_branch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch around ID-resolved branches.
//  Sits between IF and ID: drives oPC to instruction memory and oFlush_ID into the ID reset/NOP input.
//  Inserts the required bubbles after a taken branch, honours stall and halt requests.
//  Redirects fetch to the branch target carried on the ID data bus.
// PARAMETERS
//  PC_W         10   program counter width; matches the ID data bus carrying jump targets
//  FLUSH_CYCLES 1    bubbles injected after a taken branch; legal range 1..7
//  HALT_OP      6'h3F operation code that freezes fetch until reset
// PORTS
//  Clock          in   1     single system clock, rising edge
//  Reset          in   1     asynchronous, active-low; 0 = reset asserted
//  iBranchTaken   in   1     ID branch-taken flag, registered by ID
//  iBranchTarget  in   PC_W  jump target from ID data bus, valid with iBranchTaken
//  iOperation_ID  in   6     operation currently leaving ID; used for HALT_OP detect
//  iStall         in   1     downstream stall request, level-sensitive
//  oPC            out  PC_W  fetch address
//  oFetchEnable   out  1     1 = IF latches the instruction at oPC this cycle
//  oFlush_ID      out  1     1 = ID must treat its input as `NOP
//  oState         out  2     current FSM state, for debug/bench
// BEHAVIOUR
//  Reset (Reset==0, async):
//   - oPC=0, oFetchEnable=0, oFlush_ID=1, state=BOOT, flush counter=0
//  BOOT:
//   - One cycle after Reset deasserts -> RUN
//   - oFetchEnable=0 and oFlush_ID=1 in BOOT, so the first fetched word is mem[0]
//  RUN:
//   - oFetchEnable=1, oFlush_ID=0, oPC<=oPC+1 each cycle
//   - PC wraps modulo 2^PC_W; 10'h3FF+1 -> 0, no flag
//  iBranchTaken==1 in RUN, highest priority:
//   - oPC<=iBranchTarget, counter<=FLUSH_CYCLES, -> FLUSH
//  FLUSH:
//   - oFlush_ID=1 and oFetchEnable=1
//   - PC keeps incrementing from the target; counter decrements
//   - -> RUN when counter reaches 1
//   - Total bubbles seen by ID = FLUSH_CYCLES exactly
//   - iBranchTaken during FLUSH is ignored, since the flushed op cannot branch
//  iStall==1 in RUN, with no branch:
//   - -> STALL; oPC held, oFetchEnable=0, oFlush_ID=0
//  STALL:
//   - Held while iStall==1; on iStall==0 -> RUN with no PC skip
//   - iStall==1 in FLUSH is deferred: FLUSH completes, then STALL is entered if iStall is still 1
//  Simultaneous iBranchTaken and iStall in RUN:
//   - Branch wins; the stall is deferred as above
//  Halt:
//   - iOperation_ID==HALT_OP with oFlush_ID==0 -> HALT
//   - HALT: oFetchEnable=0, oFlush_ID=1, oPC held; exited only by Reset
//  Latency:
//   - Branch flag to target fetch is 1 cycle (oPC==target on the edge after iBranchTaken)
//  Reset mid-FLUSH or mid-STALL:
//   - Immediate return to the reset values; no pending branch or stall is retained
//  All outputs are registered, with no combinational input->output path.
// STRUCTURE
//  Shared package/include, next to `NOP and `BAEQ:
//   - State encodings BOOT=2'd0, RUN=2'd1, FLUSH=2'd2 (STALL and HALT below)
//   - STALL=2'd3
//   - HALT is held as a separate sticky bit and reported as oState=2'd3 with oFetchEnable=0
//   - Opcode macros; HALT_OP default value
//  Sub-module bubble_counter (3-bit load/decrement, terminal flag) holds the FLUSH count.
//  PC register and FSM stay in this module.
// TESTING
//  1 Reset release, no stall: BOOT 1 cycle, then oPC=0,1,2,3 on successive edges, oFetchEnable=1.
//  2 iBranchTaken=1, iBranchTarget=10'h120 at PC=5, FLUSH_CYCLES=1:
//    next oPC=10'h120, oFlush_ID=1 for 1 cycle, then 10'h121 with oFlush_ID=0.
//  3 iStall=1 for 3 cycles at PC=7 -> oPC stays 7, oFetchEnable=0;
//    after release oPC=8, no address skipped.
//  4 Branch and stall same cycle, target 10'h040 -> FLUSH first, then STALL while iStall=1,
//    then oPC=10'h041.
//  5 Run from PC=10'h3FE -> 10'h3FF -> 10'h000 without disturbance;
//    iOperation_ID=HALT_OP -> oFetchEnable=0 and held until Reset.
//  6 Reset asserted asynchronously mid-FLUSH (between edges) -> outputs reach reset values
//    before the next edge; FLUSH_CYCLES=3 run gives exactly 3 bubbles.

Source files
------------

// File: rtl/fetch_branch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_branch_sequencer_pkg
// Definitions shared by the fetch/branch sequencer and its bubble counter:
// FSM state encodings, default parameter values, and the helper that turns
// the FLUSH_CYCLES parameter into a legal 3-bit counter load value.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_branch_sequencer_pkg;

    // The halted condition is not a state of its own. It is a sticky bit that
    // parks the FSM in ST_STALL, so oState reads 2'd3 while halted.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_STALL = 2'd3
    } fbs_state_t;

    localparam int         PC_W_DEFAULT         = 10;
    localparam int         FLUSH_CYCLES_DEFAULT = 1;
    localparam logic [5:0] HALT_OP_DEFAULT      = 6'h3F;

    // The bubble counter is 3 bits wide and exits FLUSH at a count of 1, so
    // only 1..7 are meaningful. Out-of-range values are clamped.
    function automatic logic [2:0] flush_load(input int n);
        if (n < 1) begin
            return 3'd1;
        end
        if (n > 7) begin
            return 3'd7;
        end
        return 3'(n);
    endfunction

endpackage

// File: rtl/fetch_branch_sequencer_bubble_counter.sv
// ---------------------------------------------------------------------------
// bubble_counter
// A 3-bit down-counter that tracks the bubbles still owed after a taken
// branch. The counter loads the bubble count when the branch is accepted and
// counts down once per FLUSH cycle. It flags terminal count at 1, because the
// FSM must leave FLUSH on the edge that retires the last bubble.
// Ports:
//   Clock       in  1  system clock, rising edge
//   Reset       in  1  asynchronous reset, active low
//   iLoad       in  1  load iLoadValue (takes priority over decrement)
//   iLoadValue  in  3  bubble count to load
//   iDecrement  in  1  count down by one (saturates at 0)
//   oTerminal   out 1  1 when the count is 1 (last bubble in progress)
// ---------------------------------------------------------------------------
module bubble_counter (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLoad,
    input  logic [2:0] iLoadValue,
    input  logic       iDecrement,
    output logic       oTerminal
);

    logic [2:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= 3'd0;
        end else if (iLoad) begin
            count <= iLoadValue;
        end else if (iDecrement && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign oTerminal = (count == 3'd1);

endmodule

// File: rtl/fetch_branch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_branch_sequencer
// This module owns the program counter. It sequences instruction fetch around
// branches that ID resolves. After a taken branch it redirects fetch to the
// target and injects FLUSH_CYCLES bubbles into ID. It also honours stall
// requests from downstream and freezes fetch on the halt opcode until reset.
// All outputs are registered.
//
// Ports:
//   Clock          in   1     system clock, rising edge
//   Reset          in   1     asynchronous reset, active low
//   iBranchTaken   in   1     branch taken in ID (registered by ID)
//   iBranchTarget  in   PC_W  branch target, valid with iBranchTaken
//   iOperation_ID  in   6     opcode leaving ID, checked for HALT_OP
//   iStall         in   1     downstream stall request, level sensitive
//   oPC            out  PC_W  fetch address
//   oFetchEnable   out  1     IF latches the word at oPC this cycle
//   oFlush_ID      out  1     ID must treat its input as a NOP
//   oState         out  2     current FSM state (3 while halted)
//
// state     | meaning
// ----------+----------------------------------------------------------------
// BOOT  (0) | first cycle after reset, nothing fetched, ID flushed
// RUN   (1) | fetching sequentially, PC advances each cycle
// FLUSH (2) | fetching from branch target while ID discards bubbles
// STALL (3) | fetch paused, PC held; also the parking state while halted
// ---------------------------------------------------------------------------
module fetch_branch_sequencer
    import fetch_branch_sequencer_pkg::*;
#(
    parameter int         PC_W         = PC_W_DEFAULT,
    parameter int         FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter logic [5:0] HALT_OP      = HALT_OP_DEFAULT
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iBranchTaken,
    input  logic [PC_W-1:0] iBranchTarget,
    input  logic [5:0]      iOperation_ID,
    input  logic            iStall,
    output logic [PC_W-1:0] oPC,
    output logic            oFetchEnable,
    output logic            oFlush_ID,
    output logic [1:0]      oState
);

    localparam logic [2:0]      FLUSH_LOAD = flush_load(FLUSH_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

    fbs_state_t state;
    logic       halted;
    logic       branch_accept;
    logic       halt_req;
    logic       cnt_dec;
    logic       cnt_term;

    // A branch is accepted only in RUN. In FLUSH the op in ID is a bubble, so
    // it cannot branch. In STALL, ID is not advancing.
    assign branch_accept = (state == ST_RUN) && !halted && iBranchTaken;

    // The op in ID is real only while ID is not being flushed.
    assign halt_req = (iOperation_ID == HALT_OP) && !oFlush_ID;

    assign cnt_dec = (state == ST_FLUSH) && !cnt_term;

    bubble_counter u_bubble_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .iLoad      (branch_accept),
        .iLoadValue (FLUSH_LOAD),
        .iDecrement (cnt_dec),
        .oTerminal  (cnt_term)
    );

    // Any move into STALL holds oPC, because the word at oPC was fetched in
    // the cycle that is ending. Leaving STALL advances oPC by one, so no
    // address is skipped and none is fetched twice.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_BOOT;
            halted       <= 1'b0;
            oPC          <= '0;
            oFetchEnable <= 1'b0;
            oFlush_ID    <= 1'b1;
        end else if (!halted) begin
            case (state)
                ST_BOOT: begin
                    state        <= ST_RUN;
                    oFetchEnable <= 1'b1;
                    oFlush_ID    <= 1'b0;
                end

                ST_RUN: begin
                    if (iBranchTaken) begin
                        state        <= ST_FLUSH;
                        oPC          <= iBranchTarget;
                        oFetchEnable <= 1'b1;
                        oFlush_ID    <= 1'b1;
                    end else if (halt_req) begin
                        halted       <= 1'b1;
                        state        <= ST_STALL;
                        oFetchEnable <= 1'b0;
                        oFlush_ID    <= 1'b1;
                    end else if (iStall) begin
                        state        <= ST_STALL;
                        oFetchEnable <= 1'b0;
                        oFlush_ID    <= 1'b0;
                    end else begin
                        oPC <= oPC + PC_ONE;
                    end
                end

                ST_FLUSH: begin
                    // A stall that arrives during FLUSH is only acted on once
                    // the last bubble is out.
                    if (cnt_term) begin
                        oFlush_ID <= 1'b0;
                        if (iStall) begin
                            state        <= ST_STALL;
                            oFetchEnable <= 1'b0;
                        end else begin
                            state        <= ST_RUN;
                            oFetchEnable <= 1'b1;
                            oPC          <= oPC + PC_ONE;
                        end
                    end else begin
                        oPC <= oPC + PC_ONE;
                    end
                end

                ST_STALL: begin
                    if (halt_req) begin
                        halted       <= 1'b1;
                        oFetchEnable <= 1'b0;
                        oFlush_ID    <= 1'b1;
                    end else if (!iStall) begin
                        state        <= ST_RUN;
                        oFetchEnable <= 1'b1;
                        oFlush_ID    <= 1'b0;
                        oPC          <= oPC + PC_ONE;
                    end
                end

                default: begin
                    state        <= ST_BOOT;
                    oFetchEnable <= 1'b0;
                    oFlush_ID    <= 1'b1;
                end
            endcase
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_fetch_branch_sequencer.sv
module tb_fetch_branch_sequencer;

    logic       Clock;
    logic       Reset;
    logic       iBranchTaken;
    logic [9:0] iBranchTarget;
    logic [5:0] iOperation_ID;
    logic       iStall;

    logic [9:0] pc1, pc3;
    logic       fe1, fe3, fl1, fl3;
    logic [1:0] st1, st3;

    fetch_branch_sequencer #(.PC_W(10), .FLUSH_CYCLES(1), .HALT_OP(6'h3F)) dut1 (
        .Clock         (Clock),
        .Reset         (Reset),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .iOperation_ID (iOperation_ID),
        .iStall        (iStall),
        .oPC           (pc1),
        .oFetchEnable  (fe1),
        .oFlush_ID     (fl1),
        .oState        (st1)
    );

    fetch_branch_sequencer #(.PC_W(10), .FLUSH_CYCLES(3), .HALT_OP(6'h3F)) dut3 (
        .Clock         (Clock),
        .Reset         (Reset),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .iOperation_ID (iOperation_ID),
        .iStall        (iStall),
        .oPC           (pc3),
        .oFetchEnable  (fe3),
        .oFlush_ID     (fl3),
        .oState        (st3)
    );

    localparam logic [5:0] HALT = 6'h3F;

    typedef struct {
        logic [9:0] pc;
        logic       fe;
        logic       fl;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic       br;
        logic [9:0] tgt;
        logic [5:0] op;
        logic       stall;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   bubbles  = 0;

    vec_t vecs[26];
    vec_t vecs6[6];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic br, input logic [9:0] tgt, input logic [5:0] op,
                                input logic stall, input logic [9:0] pc, input logic fe,
                                input logic fl, input logic [1:0] st);
        vec_t v;
        v.br     = br;
        v.tgt    = tgt;
        v.op     = op;
        v.stall  = stall;
        v.exp.pc = pc;
        v.exp.fe = fe;
        v.exp.fl = fl;
        v.exp.st = st;
        return v;
    endfunction

    task automatic check_exp(input string name, input bit sel3);
        exp_t       e;
        logic [9:0] pc;
        logic       fe, fl;
        logic [1:0] st;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e  = sb.pop_front();
        pc = sel3 ? pc3 : pc1;
        fe = sel3 ? fe3 : fe1;
        fl = sel3 ? fl3 : fl1;
        st = sel3 ? st3 : st1;
        if ({pc, fe, fl, st} !== {e.pc, e.fe, e.fl, e.st}) begin
            n_fail++;
            $display("FAIL %s: got pc=%h fe=%b fl=%b st=%0d, expected pc=%h fe=%b fl=%b st=%0d",
                     name, pc, fe, fl, st, e.pc, e.fe, e.fl, e.st);
        end
    endtask

    task automatic step(input string name, input vec_t v, input bit sel3);
        iBranchTaken  = v.br;
        iBranchTarget = v.tgt;
        iOperation_ID = v.op;
        iStall        = v.stall;
        sb.push_back(v.exp);
        @(posedge Clock);
        #1;
        check_exp(name, sel3);
        @(negedge Clock);
    endtask

    task automatic chk_reset(input string name, input bit sel3);
        exp_t e;
        e.pc = 10'h000;
        e.fe = 1'b0;
        e.fl = 1'b1;
        e.st = 2'd0;
        sb.push_back(e);
        check_exp(name, sel3);
    endtask

    task automatic idle_inputs();
        iBranchTaken  = 1'b0;
        iBranchTarget = 10'h000;
        iOperation_ID = 6'h00;
        iStall        = 1'b0;
    endtask

    initial begin
        //                 br  tgt      op    stl  pc       fe  fl  st
        vecs[0]  = mk(1'b0, 10'h000, HALT, 1'b0, 10'h000, 1, 0, 2'd1);
        vecs[1]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h001, 1, 0, 2'd1);
        vecs[2]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h002, 1, 0, 2'd1);
        vecs[3]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h003, 1, 0, 2'd1);
        vecs[4]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h004, 1, 0, 2'd1);
        vecs[5]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h005, 1, 0, 2'd1);
        vecs[6]  = mk(1'b1, 10'h120, 6'h0, 1'b0, 10'h120, 1, 1, 2'd2);
        vecs[7]  = mk(1'b1, 10'h200, 6'h0, 1'b0, 10'h121, 1, 0, 2'd1);
        vecs[8]  = mk(1'b1, 10'h006, 6'h0, 1'b0, 10'h006, 1, 1, 2'd2);
        vecs[9]  = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h007, 1, 0, 2'd1);
        vecs[10] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h007, 0, 0, 2'd3);
        vecs[11] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h007, 0, 0, 2'd3);
        vecs[12] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h007, 0, 0, 2'd3);
        vecs[13] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h008, 1, 0, 2'd1);
        vecs[14] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h009, 1, 0, 2'd1);
        vecs[15] = mk(1'b1, 10'h040, 6'h0, 1'b1, 10'h040, 1, 1, 2'd2);
        vecs[16] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h040, 0, 0, 2'd3);
        vecs[17] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h040, 0, 0, 2'd3);
        vecs[18] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h041, 1, 0, 2'd1);
        vecs[19] = mk(1'b1, 10'h3FE, 6'h0, 1'b0, 10'h3FE, 1, 1, 2'd2);
        vecs[20] = mk(1'b0, 10'h000, HALT, 1'b0, 10'h3FF, 1, 0, 2'd1);
        vecs[21] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h000, 1, 0, 2'd1);
        vecs[22] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h001, 1, 0, 2'd1);
        vecs[23] = mk(1'b0, 10'h000, HALT, 1'b0, 10'h001, 0, 1, 2'd3);
        vecs[24] = mk(1'b1, 10'h100, 6'h0, 1'b1, 10'h001, 0, 1, 2'd3);
        vecs[25] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h001, 0, 1, 2'd3);

        // FLUSH_CYCLES=3: branch with a stall pending, stall deferred past 3 bubbles
        vecs6[0] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h000, 1, 0, 2'd1);
        vecs6[1] = mk(1'b1, 10'h300, 6'h0, 1'b1, 10'h300, 1, 1, 2'd2);
        vecs6[2] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h301, 1, 1, 2'd2);
        vecs6[3] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h302, 1, 1, 2'd2);
        vecs6[4] = mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h302, 0, 0, 2'd3);
        vecs6[5] = mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h303, 1, 0, 2'd1);

        Reset = 1'b1;
        idle_inputs();
        #2 Reset = 1'b0;
        #1;
        chk_reset("reset_dut1", 1'b0);
        chk_reset("reset_dut3", 1'b1);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Reset clears halt; async reset observed before the next edge
        #2 Reset = 1'b0;
        #1;
        chk_reset("halt_cleared_dut1", 1'b0);
        chk_reset("reset_dut3_again", 1'b1);
        @(negedge Clock);
        Reset = 1'b1;

        // Reset asserted between edges while dut3 is mid-FLUSH
        step("f3_boot", mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h000, 1, 0, 2'd1), 1'b1);
        step("f3_branch", mk(1'b1, 10'h2A0, 6'h0, 1'b0, 10'h2A0, 1, 1, 2'd2), 1'b1);
        step("f3_bubble2", mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h2A1, 1, 1, 2'd2), 1'b1);
        #2 Reset = 1'b0;
        #1;
        chk_reset("reset_mid_flush", 1'b1);
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step($sformatf("flush3_%0d", i), vecs6[i], 1'b1);
            if (fl3 === 1'b1) begin
                bubbles++;
            end
        end
        n_checks++;
        if (bubbles != 3) begin
            n_fail++;
            $display("FAIL bubble_count: got %0d, expected 3", bubbles);
        end

        // Reset asserted between edges while dut3 is mid-STALL
        step("stall_enter", mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h303, 0, 0, 2'd3), 1'b1);
        step("stall_hold", mk(1'b0, 10'h000, 6'h0, 1'b1, 10'h303, 0, 0, 2'd3), 1'b1);
        #2 Reset = 1'b0;
        #1;
        chk_reset("reset_mid_stall", 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        step("post_stall_boot", mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h000, 1, 0, 2'd1), 1'b1);
        step("post_stall_run", mk(1'b0, 10'h000, 6'h0, 1'b0, 10'h001, 1, 0, 2'd1), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
